// File: rtl/cv32e41s_pkg.sv
// Shared types for the control-transfer target sequencer: target mux select,
// sequencer state and default jump-vector-table geometry.
package cv32e41s_pkg;

  typedef enum logic [1:0] {
    CT_TBLJMP = 2'b00,
    CT_JAL    = 2'b01,
    CT_JALR   = 2'b10,
    CT_BCH    = 2'b11
  } bch_jmp_mux_e;

  typedef enum logic [1:0] {
    IDLE,
    TBL_REQ,
    TBL_WAIT,
    FLUSH
  } ct_seq_state_e;

  localparam int unsigned JVT_ADDR_WIDTH_DFLT  = 26;
  localparam int unsigned JVT_INDEX_WIDTH_DFLT = 8;

endpackage

// File: rtl/cv32e41s_ct_target_calc.sv
// Combinational control-transfer arithmetic: jump/branch target, link PC and
// jump-table entry address. All adds are 32-bit modulo.
module cv32e41s_ct_target_calc
  import cv32e41s_pkg::*;
#(
  parameter int unsigned JVT_ADDR_WIDTH  = JVT_ADDR_WIDTH_DFLT,
  parameter int unsigned JVT_INDEX_WIDTH = JVT_INDEX_WIDTH_DFLT
) (
  input  bch_jmp_mux_e               sel_i,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                imm_uj_i,
  input  logic [31:0]                imm_sb_i,
  input  logic [31:0]                imm_i_i,
  input  logic [31:0]                jalr_fw_i,
  input  logic [JVT_ADDR_WIDTH-1:0]  jvt_addr_i,
  input  logic [JVT_INDEX_WIDTH-1:0] jvt_index_i,
  input  logic                       compressed_i,
  input  logic                       dummy_i,
  output logic [31:0]                target_o,
  output logic [31:0]                pc_next_o,
  output logic [31:0]                tbl_addr_o
);

  logic [31:0] w_jalr_sum;

  assign w_jalr_sum = jalr_fw_i + imm_i_i;

  // Table jumps fall into the default arm: a dummy table jump acts as JALR.
  always_comb begin
    target_o = w_jalr_sum & 32'hFFFF_FFFE;
    case (sel_i)
      CT_JAL:  target_o = pc_i + imm_uj_i;
      CT_BCH:  target_o = pc_i + imm_sb_i;
      default: target_o = w_jalr_sum & 32'hFFFF_FFFE;
    endcase
  end

  assign pc_next_o  = pc_i + (dummy_i ? 32'd0 : (compressed_i ? 32'd2 : 32'd4));
  assign tbl_addr_o = {jvt_addr_i, {(32-JVT_ADDR_WIDTH){1'b0}}}
                    + (32'(jvt_index_i) << 2);

endmodule

// File: rtl/cv32e41s_ct_target_seq.sv
// Registered control-transfer target unit with jump-table memory reads.
// Optional one-entry table cache: define CV32E41S_PCT_TBLJMP_CACHE_EN.
module cv32e41s_ct_target_seq
  import cv32e41s_pkg::*;
#(
  parameter int unsigned JVT_ADDR_WIDTH  = JVT_ADDR_WIDTH_DFLT,
  parameter int unsigned JVT_INDEX_WIDTH = JVT_INDEX_WIDTH_DFLT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  bch_jmp_mux_e               sel_i,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                imm_uj_i,
  input  logic [31:0]                imm_sb_i,
  input  logic [31:0]                imm_i_i,
  input  logic [31:0]                jalr_fw_i,
  input  logic [JVT_ADDR_WIDTH-1:0]  jvt_addr_i,
  input  logic [JVT_INDEX_WIDTH-1:0] jvt_index_i,
  input  logic                       compressed_i,
  input  logic                       dummy_i,
  input  logic                       kill_i,
  output logic                       tbl_req_o,
  output logic [31:0]                tbl_addr_o,
  input  logic                       tbl_gnt_i,
  input  logic                       tbl_rvalid_i,
  input  logic [31:0]                tbl_rdata_i,
  input  logic                       tbl_err_i,
  output logic                       target_valid_o,
  input  logic                       target_ready_i,
  output logic [31:0]                target_o,
  output logic [31:0]                pc_next_o,
  output logic                       target_err_o
);

  ct_seq_state_e r_state, w_state_nxt;

  logic        r_valid, r_err;
  logic [31:0] r_target, r_pc_next, r_tbl_addr;
  logic [31:0] w_target, w_pc_next, w_tbl_addr, w_hit_target;
  logic        w_accept, w_is_tbl, w_hit, w_tbl_issue, w_resp;

  cv32e41s_ct_target_calc #(
    .JVT_ADDR_WIDTH  (JVT_ADDR_WIDTH),
    .JVT_INDEX_WIDTH (JVT_INDEX_WIDTH)
  ) u_calc (
    .sel_i        (sel_i),
    .pc_i         (pc_i),
    .imm_uj_i     (imm_uj_i),
    .imm_sb_i     (imm_sb_i),
    .imm_i_i      (imm_i_i),
    .jalr_fw_i    (jalr_fw_i),
    .jvt_addr_i   (jvt_addr_i),
    .jvt_index_i  (jvt_index_i),
    .compressed_i (compressed_i),
    .dummy_i      (dummy_i),
    .target_o     (w_target),
    .pc_next_o    (w_pc_next),
    .tbl_addr_o   (w_tbl_addr)
  );

  assign ready_o     = (r_state == IDLE) && (!r_valid || target_ready_i);
  assign w_accept    = valid_i && ready_o && !kill_i;
  assign w_is_tbl    = (sel_i == CT_TBLJMP) && !dummy_i;
  assign w_tbl_issue = w_accept && w_is_tbl && !w_hit;
  assign w_resp      = (r_state == TBL_WAIT) && tbl_rvalid_i && !kill_i;

`ifdef CV32E41S_PCT_TBLJMP_CACHE_EN
  logic                       r_c_valid;
  logic [JVT_ADDR_WIDTH-1:0]  r_c_base, r_req_base;
  logic [JVT_INDEX_WIDTH-1:0] r_c_index, r_req_index;
  logic [31:0]                r_c_target;

  assign w_hit        = w_is_tbl && r_c_valid && (r_c_base == jvt_addr_i)
                     && (r_c_index == jvt_index_i);
  assign w_hit_target = r_c_target;

  // A fresh fill overrides the stale-base check; a kill mid-fill wins over both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_valid   <= 1'b0;
      r_c_base    <= '0;
      r_c_index   <= '0;
      r_c_target  <= '0;
      r_req_base  <= '0;
      r_req_index <= '0;
    end else begin
      if (w_tbl_issue) begin
        r_req_base  <= jvt_addr_i;
        r_req_index <= jvt_index_i;
      end
      if (kill_i && ((r_state == TBL_REQ) || (r_state == TBL_WAIT))) begin
        r_c_valid <= 1'b0;
      end else if (w_resp && !tbl_err_i) begin
        r_c_valid  <= 1'b1;
        r_c_base   <= r_req_base;
        r_c_index  <= r_req_index;
        r_c_target <= tbl_rdata_i & 32'hFFFF_FFFE;
      end else if (r_c_base != jvt_addr_i) begin
        r_c_valid <= 1'b0;
      end
    end
  end
`else
  assign w_hit        = 1'b0;
  assign w_hit_target = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_tbl_issue) w_state_nxt = TBL_REQ;
      TBL_REQ: begin
        if (tbl_gnt_i)   w_state_nxt = kill_i ? FLUSH : TBL_WAIT;
        else if (kill_i) w_state_nxt = IDLE;
      end
      TBL_WAIT: begin
        if (tbl_rvalid_i) w_state_nxt = IDLE;
        else if (kill_i)  w_state_nxt = FLUSH;
      end
      FLUSH:    if (tbl_rvalid_i) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A table issue implies the output is empty or being popped, so the
  // final pop branch also retires any previous result in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_target   <= '0;
      r_pc_next  <= '0;
      r_tbl_addr <= '0;
    end else begin
      if (kill_i) begin
        r_valid <= 1'b0;
      end else if (w_accept && !w_tbl_issue) begin
        r_valid   <= 1'b1;
        r_target  <= w_hit ? w_hit_target : w_target;
        r_pc_next <= w_pc_next;
        r_err     <= 1'b0;
      end else if (w_resp) begin
        r_valid  <= 1'b1;
        r_target <= tbl_rdata_i & 32'hFFFF_FFFE;
        r_err    <= tbl_err_i;
      end else if (r_valid && target_ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_tbl_issue) begin
        r_pc_next  <= w_pc_next;
        r_tbl_addr <= w_tbl_addr;
      end
    end
  end

  assign tbl_req_o      = (r_state == TBL_REQ);
  assign tbl_addr_o     = r_tbl_addr;
  assign target_valid_o = r_valid;
  assign target_o       = r_target;
  assign pc_next_o      = r_pc_next;
  assign target_err_o   = r_err;

endmodule

// File: tb/tb_cv32e41s_ct_target_seq.sv
// Randomized self-checking bench for cv32e41s_ct_target_seq against a
// transaction-level reference model (cache model active with CV32E41S_PCT_TBLJMP_CACHE_EN).
module tb_cv32e41s_ct_target_seq;
  import cv32e41s_pkg::*;

  localparam int unsigned AW = 26;
  localparam int unsigned IW = 8;
`ifdef CV32E41S_PCT_TBLJMP_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic          clk, rst_n, valid_i, ready_o;
  bch_jmp_mux_e  sel_i;
  logic [31:0]   pc_i, imm_uj_i, imm_sb_i, imm_i_i, jalr_fw_i;
  logic [AW-1:0] jvt_addr_i;
  logic [IW-1:0] jvt_index_i;
  logic          compressed_i, dummy_i, kill_i;
  logic          tbl_req_o, tbl_gnt_i, tbl_rvalid_i, tbl_err_i;
  logic [31:0]   tbl_addr_o, tbl_rdata_i;
  logic          target_valid_o, target_ready_i, target_err_o;
  logic [31:0]   target_o, pc_next_o;

  cv32e41s_ct_target_seq #(
    .JVT_ADDR_WIDTH  (AW),
    .JVT_INDEX_WIDTH (IW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .sel_i          (sel_i),
    .pc_i           (pc_i),
    .imm_uj_i       (imm_uj_i),
    .imm_sb_i       (imm_sb_i),
    .imm_i_i        (imm_i_i),
    .jalr_fw_i      (jalr_fw_i),
    .jvt_addr_i     (jvt_addr_i),
    .jvt_index_i    (jvt_index_i),
    .compressed_i   (compressed_i),
    .dummy_i        (dummy_i),
    .kill_i         (kill_i),
    .tbl_req_o      (tbl_req_o),
    .tbl_addr_o     (tbl_addr_o),
    .tbl_gnt_i      (tbl_gnt_i),
    .tbl_rvalid_i   (tbl_rvalid_i),
    .tbl_rdata_i    (tbl_rdata_i),
    .tbl_err_i      (tbl_err_i),
    .target_valid_o (target_valid_o),
    .target_ready_i (target_ready_i),
    .target_o       (target_o),
    .pc_next_o      (pc_next_o),
    .target_err_o   (target_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: arithmetic straight from the instruction semantics.
  function automatic logic [31:0] m_pc_next(input logic [31:0] pc, input bit comp, input bit dummy);
    if (dummy) return pc;
    return comp ? pc + 32'd2 : pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_target(input bch_jmp_mux_e sel, input logic [31:0] pc,
      input logic [31:0] uj, input logic [31:0] sb, input logic [31:0] ii, input logic [31:0] fw);
    if (sel == CT_JAL) return pc + uj;
    if (sel == CT_BCH) return pc + sb;
    return (fw + ii) & 32'hFFFF_FFFE;
  endfunction

  function automatic logic [31:0] m_tbl_addr(input logic [AW-1:0] base, input logic [IW-1:0] idx);
    logic [31:0] b;
    b = 32'(base);
    return (b << (32 - AW)) + 32'(idx) * 32'd4;
  endfunction

  bit            m_c_valid = 1'b0;
  logic [AW-1:0] m_c_base  = '0;
  logic [IW-1:0] m_c_idx   = '0;
  logic [31:0]   m_c_tgt   = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_out(input int unsigned hold, input logic [31:0] tgt);
    for (int unsigned h = 0; h < hold; h++) begin
      #1 check("held_ready", ready_o, 0);
      step();
      check("held_valid", target_valid_o, 1);
      check("held_target", target_o, tgt);
    end
    target_ready_i = 1'b1;
    #1 check("pop_ready", ready_o, 1);
    step();
    target_ready_i = 1'b0;
    check("popped_valid", target_valid_o, 0);
  endtask

  task automatic flush_wait(input int unsigned fdly);
    m_c_valid = 1'b0;
    sel_i = CT_JAL;
    dummy_i = 1'b0;
    valid_i = 1'b1;
    for (int unsigned f = 0; f < fdly; f++) begin
      #1 check("flush_ready", ready_o, 0);
      step();
      check("flush_valid", target_valid_o, 0);
    end
    tbl_rvalid_i = 1'b1;
    tbl_rdata_i  = $urandom;
    step();
    tbl_rvalid_i = 1'b0;
    valid_i = 1'b0;
    check("flush_drop_valid", target_valid_o, 0);
    check("flush_done_ready", ready_o, 1);
  endtask

  // kmode: 0 none, 1 kill in TBL_REQ, 2 kill with grant, 3 kill in TBL_WAIT,
  // 4 kill with rvalid, 5 kill while a non-table result is held.
  task automatic run_ct(input bch_jmp_mux_e sel, input logic [31:0] pc, input logic [31:0] uj,
      input logic [31:0] sb, input logic [31:0] ii, input logic [31:0] fw,
      input logic [AW-1:0] base, input logic [IW-1:0] idx, input bit comp, input bit dummy,
      input int unsigned kmode, input int unsigned gdly, input int unsigned rdly,
      input logic [31:0] rdata, input bit err, input int unsigned hold);
    bit          is_tbl, hit;
    logic [31:0] exp_tgt, exp_pn, exp_addr;
    if (m_c_valid && (m_c_base != base)) m_c_valid = 1'b0;
    is_tbl   = (sel == CT_TBLJMP) && !dummy;
    hit      = CACHE_EN && is_tbl && m_c_valid && (m_c_idx == idx);
    exp_pn   = m_pc_next(pc, comp, dummy);
    exp_addr = m_tbl_addr(base, idx);
    exp_tgt  = hit ? m_c_tgt : m_target(sel, pc, uj, sb, ii, fw);

    sel_i = sel; pc_i = pc; imm_uj_i = uj; imm_sb_i = sb; imm_i_i = ii; jalr_fw_i = fw;
    jvt_addr_i = base; jvt_index_i = idx; compressed_i = comp; dummy_i = dummy;
    valid_i = 1'b1;
    #1 check("accept_ready", ready_o, 1);
    step();
    valid_i = 1'b0;

    if (!is_tbl || hit) begin
      check("ct_valid", target_valid_o, 1);
      check("ct_target", target_o, exp_tgt);
      check("ct_pc_next", pc_next_o, exp_pn);
      check("ct_err", target_err_o, 0);
      check("ct_no_req", tbl_req_o, 0);
      if (kmode == 5) begin
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        check("kill_clears_valid", target_valid_o, 0);
      end else begin
        pop_out(hold, exp_tgt);
      end
      return;
    end

    check("tbl_req", tbl_req_o, 1);
    check("tbl_addr", tbl_addr_o, exp_addr);
    check("tbl_busy_ready", ready_o, 0);
    for (int unsigned g = 0; g < gdly; g++) begin
      step();
      check("tbl_req_hold", tbl_req_o, 1);
      check("tbl_addr_hold", tbl_addr_o, exp_addr);
    end
    if (kmode == 1) begin
      kill_i = 1'b1;
      step();
      kill_i = 1'b0;
      m_c_valid = 1'b0;
      check("kill_req_drop", tbl_req_o, 0);
      check("kill_req_ready", ready_o, 1);
      check("kill_req_valid", target_valid_o, 0);
      return;
    end
    tbl_gnt_i = 1'b1;
    kill_i = (kmode == 2);
    step();
    tbl_gnt_i = 1'b0;
    kill_i = 1'b0;
    check("gnt_req_drop", tbl_req_o, 0);
    if (kmode == 2 || kmode == 3) begin
      if (kmode == 3) begin
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
      end
      flush_wait(rdly + 1);
      return;
    end
    for (int unsigned r = 0; r < rdly; r++) begin
      #1 check("wait_ready", ready_o, 0);
      step();
      check("wait_valid", target_valid_o, 0);
      check("wait_no_req", tbl_req_o, 0);
    end
    tbl_rvalid_i = 1'b1;
    tbl_rdata_i  = rdata;
    tbl_err_i    = err;
    kill_i       = (kmode == 4);
    step();
    tbl_rvalid_i = 1'b0;
    tbl_err_i    = 1'b0;
    kill_i       = 1'b0;
    if (kmode == 4) begin
      m_c_valid = 1'b0;
      check("kill_rsp_valid", target_valid_o, 0);
      check("kill_rsp_ready", ready_o, 1);
      return;
    end
    check("tbl_valid", target_valid_o, 1);
    check("tbl_target", target_o, rdata & 32'hFFFF_FFFE);
    check("tbl_err", target_err_o, 32'(err));
    check("tbl_pc_next", pc_next_o, exp_pn);
    if (!err) begin
      m_c_valid = 1'b1; m_c_base = base; m_c_idx = idx; m_c_tgt = rdata & 32'hFFFF_FFFE;
    end
    pop_out(hold, rdata & 32'hFFFF_FFFE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; sel_i = CT_JAL; pc_i = '0; imm_uj_i = '0; imm_sb_i = '0;
    imm_i_i = '0; jalr_fw_i = '0; jvt_addr_i = '0; jvt_index_i = '0; compressed_i = 1'b0;
    dummy_i = 1'b0; kill_i = 1'b0; tbl_gnt_i = 1'b0; tbl_rvalid_i = 1'b0; tbl_rdata_i = '0;
    tbl_err_i = 1'b0; target_ready_i = 1'b0;
    #3;
    check("rst_valid", target_valid_o, 0);
    check("rst_target", target_o, 0);
    check("rst_pc_next", pc_next_o, 0);
    check("rst_err", target_err_o, 0);
    check("rst_req", tbl_req_o, 0);
    check("rst_addr", tbl_addr_o, 0);
    check("rst_ready", ready_o, 1);
    #9 rst_n = 1'b1;
    step();

    // Directed cases
    run_ct(CT_JAL, 32'h100, 32'h20, 0, 0, 0, 26'h200_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_ct(CT_JALR, 32'h300, 0, 0, 32'h0, 32'h2003, 26'h200_0000, 0, 1, 0, 0, 0, 0, 0, 0, 3);
    run_ct(CT_TBLJMP, 32'h400, 0, 0, 0, 0, 26'h200_0000, 8'd5, 0, 0, 0, 2, 1, 32'h4001, 0, 1);
    run_ct(CT_TBLJMP, 32'h500, 0, 0, 0, 0, 26'h200_0000, 8'd6, 1, 0, 0, 0, 0, 32'h7777, 1, 0);
    run_ct(CT_TBLJMP, 32'h600, 0, 0, 0, 0, 26'h200_0000, 8'd5, 0, 0, 3, 1, 2, 0, 0, 0);
    run_ct(CT_JAL, 32'hFFFF_FFFC, 32'h8, 0, 0, 0, 26'h200_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_ct(CT_TBLJMP, 32'h700, 0, 0, 0, 0, 26'h200_0000, 8'd5, 0, 0, 0, 1, 0, 32'h4001, 0, 0);
    run_ct(CT_TBLJMP, 32'h704, 0, 0, 0, 0, 26'h200_0000, 8'd5, 1, 0, 0, 1, 0, 32'h4001, 0, 0);
    run_ct(CT_TBLJMP, 32'h708, 0, 0, 0, 0, 26'h3FF_FFFF, 8'd5, 0, 0, 0, 0, 0, 32'h9001, 0, 0);
    run_ct(CT_TBLJMP, 32'h70C, 0, 0, 0, 0, 26'h3FF_FFFF, 8'hFF, 0, 0, 0, 0, 0, 32'h1234, 0, 0);
    run_ct(CT_TBLJMP, 32'h800, 0, 0, 32'h11, 32'h20, 26'h200_0000, 8'd5, 0, 1, 0, 0, 0, 0, 0, 0);

    // Back-to-back: a new accept in the same cycle as the pop.
    sel_i = CT_JAL; pc_i = 32'h1000; imm_uj_i = 32'h10; compressed_i = 1'b0; dummy_i = 1'b0;
    valid_i = 1'b1;
    step();
    check("b2b_first", target_o, 32'h1010);
    pc_i = 32'h2000; imm_uj_i = 32'h44; compressed_i = 1'b1; target_ready_i = 1'b1;
    #1 check("b2b_ready", ready_o, 1);
    step();
    valid_i = 1'b0; target_ready_i = 1'b0;
    check("b2b_valid", target_valid_o, 1);
    check("b2b_target", target_o, 32'h2044);
    check("b2b_pc_next", pc_next_o, 32'h2002);
    pop_out(0, 32'h2044);

    // Randomized transactions
    for (int i = 0; i < 300; i++) begin
      bch_jmp_mux_e  sel;
      logic [AW-1:0] base;
      logic [IW-1:0] idx;
      logic [31:0]   pc;
      int unsigned   km, roll;
      case ($urandom_range(0, 4))
        0: sel = CT_JAL;
        1: sel = CT_BCH;
        2: sel = CT_JALR;
        default: sel = CT_TBLJMP;
      endcase
      base = ($urandom_range(0, 2) == 0) ? AW'($urandom) : 26'h200_0000;
      case ($urandom_range(0, 4))
        0: idx = 8'hFF;
        default: idx = IW'($urandom_range(0, 3));
      endcase
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      roll = $urandom_range(0, 9);
      km = 0;
      if (sel == CT_TBLJMP && roll < 4) km = roll + 1;
      else if (sel != CT_TBLJMP && roll == 0) km = 5;
      run_ct(sel, pc, $urandom, $urandom, $urandom, $urandom, base, idx,
             1'($urandom), ($urandom_range(0, 7) == 0), km, $urandom_range(0, 2),
             $urandom_range(0, 2), $urandom, ($urandom_range(0, 5) == 0), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
